mux_sequencer: RTL and testbench

- Sequences the 4-channel output multiplexer: selects which channel drives the 4-bit one-hot `saida` and how long it dwells there.
- Uses an internal prescaler that produces a single-cycle enable from `clk`; no derived clocks.
- Channels advance round-robin and skip any channel masked off.
- Sits between the board clock and the display/LED mux path; the rest of the design reads `saida` and `sel`.

---
 rtl/mux_sequencer_pkg.sv | 12 +
 rtl/mux_sequencer_tick_prescaler.sv | 31 +++
 rtl/mux_sequencer.sv | 123 ++++++++++++
 tb/tb_mux_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_sequencer_pkg.sv
// Shared constants and state encoding for the output-mux sequencer.
package mux_sequencer_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/mux_sequencer_tick_prescaler.sv
// Free-running divider that emits a one-cycle enable every TICK_DIV clocks
// of counting. The count freezes while en is low, so a paused block resumes
// mid-period instead of restarting it.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1 while enabled, wrapping to zero after the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Gated by en and rst so a frozen or resetting counter parked on LAST
  // never emits a tick.
  assign tick = en & ~rst & (count == LAST);

endmodule

// File: rtl/mux_sequencer.sv
// Round-robin sequencer for the 4-channel output mux: dwells HOLD_TICKS
// prescaler ticks on each participating channel, then steps to the next one.
//
//   state | meaning
//   IDLE  | no channel driven (saida = 0), waiting for enable and a non-empty mask
//   RUN   | saida drives channel sel; counting dwell ticks
module mux_sequencer
  import mux_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int HOLD_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [N_CH-1:0]  saida,
  output logic [SEL_W-1:0] sel,
  output logic             tick,
  output logic             advance
);

  localparam int            DW     = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [DW-1:0] LAST_D = DW'(HOLD_TICKS - 1);

  seq_state_t       state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [N_CH-1:0]  saida_n;
  logic [DW-1:0]    dwell, dwell_n;
  logic             advance_n;

  // First set bit of mask strictly after cur, wrapping; returns cur itself
  // when it is the only set bit. The mask is rotated so bit 0 lines up with
  // cur+1, then a priority scan picks the lowest set bit.
  function automatic logic [SEL_W-1:0] next_ch(input logic [N_CH-1:0]  mask,
                                              input logic [SEL_W-1:0] cur);
    logic [2*N_CH-1:0] dbl;
    logic [2*N_CH-1:0] shifted;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  inc;
    logic [SEL_W-1:0]  off;
    inc     = cur + SEL_W'(1);
    dbl     = {mask, mask};
    shifted = dbl >> inc;
    rot     = shifted[N_CH-1:0];
    off     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    return inc + off;
  endfunction

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .tick (tick)
  );

  // Register state and all outputs so saida/sel/advance change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      saida   <= '0;
      dwell   <= '0;
      advance <= 1'b0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      saida   <= saida_n;
      dwell   <= dwell_n;
      advance <= advance_n;
    end
  end

  // Next-state and output decode; an emptied mask wins over everything,
  // then pause, then a masked-off current channel, then the dwell timer.
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    dwell_n   = dwell;
    advance_n = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (ch_mask != '0)) begin
          state_n   = RUN;
          sel_n     = next_ch(ch_mask, SEL_W'(N_CH - 1));
          dwell_n   = '0;
          advance_n = 1'b1;
        end
      end
      RUN: begin
        if (ch_mask == '0) begin
          state_n = IDLE;
          dwell_n = '0;
        end else if (enable) begin
          if (!ch_mask[sel]) begin
            sel_n     = next_ch(ch_mask, sel);
            dwell_n   = '0;
            advance_n = 1'b1;
          end else if (tick) begin
            if (dwell == LAST_D) begin
              sel_n     = next_ch(ch_mask, sel);
              dwell_n   = '0;
              advance_n = 1'b1;
            end else begin
              dwell_n = dwell + 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        dwell_n = '0;
      end
    endcase
    saida_n = (state_n == RUN) ? (N_CH'(1) << sel_n) : '0;
  end

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed phases from the sequencing scenarios followed by a random soak,
// every cycle compared against a cycle-level behavioural model.
module tb_mux_sequencer;

  localparam int DIV  = 4;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] ch_mask;
  logic [3:0] saida;
  logic [1:0] sel;
  logic       tick;
  logic       advance;

  int checks   = 0;
  int failures = 0;

  // behavioural model state (values after the most recent posedge)
  int         m_presc = 0;
  int         m_dwell = 0;
  bit         m_run   = 1'b0;
  int         m_ch    = 0;
  bit         m_adv   = 1'b0;
  logic [3:0] m_saida = 4'b0000;

  mux_sequencer #(
    .TICK_DIV   (DIV),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .ch_mask (ch_mask),
    .saida   (saida),
    .sel     (sel),
    .tick    (tick),
    .advance (advance)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_enabled(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  function automatic int lowest_enabled(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [3:0] m);
    bit t;
    if (r) begin
      m_presc = 0; m_dwell = 0; m_run = 0; m_ch = 0; m_adv = 0;
    end else begin
      t     = e && (m_presc == DIV - 1);
      if (e) m_presc = (m_presc + 1) % DIV;
      m_adv = 0;
      if (!m_run) begin
        if (e && m != 0) begin
          m_run = 1; m_ch = lowest_enabled(m); m_dwell = 0; m_adv = 1;
        end
      end else if (m == 0) begin
        m_run = 0; m_dwell = 0;
      end else if (e) begin
        if (!m[m_ch]) begin
          m_ch = next_enabled(m_ch, m); m_dwell = 0; m_adv = 1;
        end else if (t) begin
          if (m_dwell == HOLD - 1) begin
            m_ch = next_enabled(m_ch, m); m_dwell = 0; m_adv = 1;
          end else begin
            m_dwell++;
          end
        end
      end
    end
    m_saida = m_run ? (4'b0001 << m_ch) : 4'b0000;
  endtask

  // Apply inputs just after a falling edge, check the combinational tick,
  // advance the model across the rising edge, then check registered outputs
  // at the next falling edge.
  task automatic cycle(input bit r, input bit e, input logic [3:0] m);
    rst = r; enable = e; ch_mask = m;
    #1;
    check("tick", tick, (!r && e && m_presc == DIV - 1));
    model_edge(r, e, m);
    @(negedge clk);
    check("saida", saida, m_saida);
    check("sel", sel, m_ch);
    check("advance", advance, m_adv);
  endtask

  initial begin
    int n;
    logic [3:0] rmask;
    rst = 1'b1; enable = 1'b0; ch_mask = 4'b0000;
    @(negedge clk);
    cycle(1, 0, 4'b0000);
    cycle(1, 0, 4'b0000);

    // full rotation, then alternating pair
    repeat (70) cycle(0, 1, 4'b1111);
    repeat (50) cycle(0, 1, 4'b1010);

    // mask off the active channel while it is channel 2
    n = 0;
    while (saida !== 4'b0100 && n < 64) begin
      cycle(0, 1, 4'b1111);
      n++;
    end
    check("reach_ch2", saida, 4'b0100);
    cycle(0, 1, 4'b1011);
    check("maskoff_jump", saida, 4'b1000);
    check("maskoff_adv", advance, 1'b1);
    repeat (20) cycle(0, 1, 4'b1011);

    // pause mid-dwell and resume
    repeat (3) cycle(0, 1, 4'b1011);
    repeat (20) cycle(0, 0, 4'b1011);
    repeat (20) cycle(0, 1, 4'b1011);

    // empty mask drops to idle, single channel restarts
    cycle(0, 1, 4'b0000);
    check("idle_saida", saida, 4'b0000);
    repeat (3) cycle(0, 1, 4'b0000);
    cycle(0, 1, 4'b0100);
    check("single_start", saida, 4'b0100);
    repeat (30) cycle(0, 1, 4'b0100);

    // reset while on channel 3
    n = 0;
    while (saida !== 4'b1000 && n < 64) begin
      cycle(0, 1, 4'b1111);
      n++;
    end
    check("reach_ch3", saida, 4'b1000);
    cycle(0, 1, 4'b1111);
    cycle(1, 1, 4'b1111);
    check("rst_saida", saida, 4'b0000);
    check("rst_sel", sel, 2'd0);
    cycle(0, 1, 4'b1111);
    check("rst_restart", saida, 4'b0001);

    // random soak
    rmask = 4'b1111;
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) rmask = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0, rmask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
